// File: rtl/multicore_mutex_bank.sv
// multicore_mutex_bank
//
// Bank of NUM_MUTEX hardware mutexes behind one Avalon-MM slave. Each mutex
// is a 32-bit word {owner[15:0], value[15:0]} with a compare-and-set rule:
// a write succeeds when the mutex is free (value == 0) or the writer's owner
// ID matches the current owner. Each mutex also has a status word with
// sticky flags. An optional per-mutex lease (TIMEOUT_CYCLES > 0)
// force-releases a mutex that has been held for too long.
//
// Optional feature macro: MULTICORE_MUTEX_RELEASE_IRQ_EN
//   When it is defined, each mutex has an irq_en bit and a release_pending
//   bit, and irq is raised on releases. When it is undefined, status bits
//   [3:2] read 0 and irq is tied to 0.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   address        word address: [ADDR_WIDTH-1:1] mutex index,
//                  [0] 0 = mutex word, 1 = status word
//   chipselect     slave select
//   read / write   access strobes
//   data_from_cpu  write data
//   data_to_cpu    registered read data, valid the cycle after read
//   irq            level release interrupt
//
// Status word: [0] reset_flag, [1] timeout_flag, [2] irq_en,
//              [3] release_pending, [31:4] zero.

module multicore_mutex_bank #(
    parameter int NUM_MUTEX      = 4,
    parameter int ADDR_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMEOUT_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           data_from_cpu,
    output logic [31:0]           data_to_cpu,
    output logic                  irq
);

    localparam int IDX_W    = ADDR_WIDTH - 1;
    localparam bit LEASE_EN = (TIMEOUT_CYCLES > 0) && (TIMEOUT_WIDTH > 0);

    logic [IDX_W-1:0]     idx;
    logic                 sel;
    logic                 in_range;
    logic [NUM_MUTEX-1:0] hit;
    logic [NUM_MUTEX-1:0] mw_hit;
    logic [NUM_MUTEX-1:0] sw_hit;

    logic [15:0]          value_q [NUM_MUTEX];
    logic [15:0]          value_d [NUM_MUTEX];
    logic [15:0]          owner_q [NUM_MUTEX];
    logic [15:0]          owner_d [NUM_MUTEX];
    logic [NUM_MUTEX-1:0] reset_flag_q, reset_flag_d;
    logic [NUM_MUTEX-1:0] timeout_flag_q, timeout_flag_d;
    logic [NUM_MUTEX-1:0] wr_ok;
    logic [NUM_MUTEX-1:0] expire;
    logic [NUM_MUTEX-1:0] irq_en_v;
    logic [NUM_MUTEX-1:0] rel_pend_v;
    logic [31:0]          rdata_q, rdata_d;

    assign idx      = address[ADDR_WIDTH-1:1];
    assign sel      = address[0];
    assign in_range = (32'(idx) < NUM_MUTEX);
    // One-hot decode; an out-of-range index selects nothing, so reads give
    // 0 and writes are dropped without further qualification.
    assign hit      = in_range ? (NUM_MUTEX'(1) << idx) : '0;
    assign mw_hit   = hit & {NUM_MUTEX{chipselect & write & ~sel}};
    assign sw_hit   = hit & {NUM_MUTEX{chipselect & write &  sel}};

    // Kept separate from the next-state block: the lease logic consumes
    // wr_ok and produces expire, which that block then uses.
    always_comb begin
        for (int i = 0; i < NUM_MUTEX; i++) begin
            wr_ok[i] = mw_hit[i] &&
                       ((value_q[i] == 16'd0) || (owner_q[i] == data_from_cpu[31:16]));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MUTEX; i++) begin
            value_d[i] = value_q[i];
            owner_d[i] = owner_q[i];
            // A successful write takes priority over lease expiry.
            if (wr_ok[i]) begin
                value_d[i] = data_from_cpu[15:0];
                owner_d[i] = data_from_cpu[31:16];
            end else if (expire[i]) begin
                value_d[i] = 16'd0;
                owner_d[i] = 16'd0;
            end
            reset_flag_d[i]   = reset_flag_q[i] & ~(sw_hit[i] & data_from_cpu[0]);
            timeout_flag_d[i] = expire[i] |
                                (timeout_flag_q[i] & ~(sw_hit[i] & data_from_cpu[1]));
        end
    end

    generate
        if (LEASE_EN) begin : g_lease
            localparam logic [TIMEOUT_WIDTH-1:0] LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
            logic [TIMEOUT_WIDTH-1:0] lease_q [NUM_MUTEX];
            logic [TIMEOUT_WIDTH-1:0] lease_d [NUM_MUTEX];

            always_comb begin
                for (int i = 0; i < NUM_MUTEX; i++) begin
                    expire[i] = (value_q[i] != 16'd0) && (lease_q[i] == LAST) && !wr_ok[i];
                    if (wr_ok[i] || expire[i] || (value_q[i] == 16'd0)) begin
                        lease_d[i] = '0;
                    end else begin
                        lease_d[i] = lease_q[i] + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < NUM_MUTEX; i++) lease_q[i] <= '0;
                end else begin
                    for (int i = 0; i < NUM_MUTEX; i++) lease_q[i] <= lease_d[i];
                end
            end
        end else begin : g_no_lease
            assign expire = '0;
        end
    endgenerate

`ifdef MULTICORE_MUTEX_RELEASE_IRQ_EN
    logic [NUM_MUTEX-1:0] irq_en_q, irq_en_d;
    logic [NUM_MUTEX-1:0] rel_pend_q, rel_pend_d;
    logic [NUM_MUTEX-1:0] released;
    logic                 irq_q, irq_d;

    always_comb begin
        for (int i = 0; i < NUM_MUTEX; i++) begin
            // Any nonzero -> zero transition counts: owner release or expiry.
            released[i]   = (value_q[i] != 16'd0) && (value_d[i] == 16'd0);
            irq_en_d[i]   = sw_hit[i] ? data_from_cpu[2] : irq_en_q[i];
            // Set beats a simultaneous write-1-clear.
            rel_pend_d[i] = released[i] |
                            (rel_pend_q[i] & ~(sw_hit[i] & data_from_cpu[3]));
        end
        irq_d = |(rel_pend_q & irq_en_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q   <= '0;
            rel_pend_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_en_q   <= irq_en_d;
            rel_pend_q <= rel_pend_d;
            irq_q      <= irq_d;
        end
    end

    assign irq_en_v   = irq_en_q;
    assign rel_pend_v = rel_pend_q;
    assign irq        = irq_q;
`else
    assign irq_en_v   = '0;
    assign rel_pend_v = '0;
    assign irq        = 1'b0;
`endif

    // Reads sample pre-edge state, so a read coinciding with a write to the
    // same word returns the old contents.
    always_comb begin
        rdata_d = rdata_q;
        if (chipselect && read) begin
            rdata_d = '0;
            for (int i = 0; i < NUM_MUTEX; i++) begin
                if (hit[i]) begin
                    rdata_d = sel ? {28'd0, rel_pend_v[i], irq_en_v[i],
                                     timeout_flag_q[i], reset_flag_q[i]}
                                  : {owner_q[i], value_q[i]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MUTEX; i++) begin
                value_q[i] <= '0;
                owner_q[i] <= '0;
            end
            reset_flag_q   <= '1;
            timeout_flag_q <= '0;
            rdata_q        <= '0;
        end else begin
            for (int i = 0; i < NUM_MUTEX; i++) begin
                value_q[i] <= value_d[i];
                owner_q[i] <= owner_d[i];
            end
            reset_flag_q   <= reset_flag_d;
            timeout_flag_q <= timeout_flag_d;
            rdata_q        <= rdata_d;
        end
    end

    assign data_to_cpu = rdata_q;

endmodule

// File: tb/tb_multicore_mutex_bank.sv
module tb_multicore_mutex_bank;

`ifdef MULTICORE_MUTEX_RELEASE_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] data_from_cpu;
    logic [31:0] data_to_cpu;
    logic        irq;

    int n_vec;
    int n_err;

    multicore_mutex_bank #(
        .NUM_MUTEX     (4),
        .ADDR_WIDTH    (4),
        .TIMEOUT_CYCLES(10),
        .TIMEOUT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .data_from_cpu(data_from_cpu),
        .data_to_cpu  (data_to_cpu),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // All bus tasks are entered at a negedge and return at the next one.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; data_from_cpu = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        chk(tag, data_to_cpu, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        data_from_cpu = '0;
        idle(2);
        chk("rst_rdata", data_to_cpu, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;

        // status after reset and reset_flag clear
        rd("st0_reset", 4'd1, 32'h1);
        wr(4'd1, 32'h1);
        rd("st0_clear", 4'd1, 32'h0);
        rd("st3_reset", 4'd7, 32'h1);

        // compare-and-set on mutex 1
        wr(4'd2, 32'h0002_0001);
        wr(4'd2, 32'h0005_0007);
        rd("m1_fail", 4'd2, 32'h0002_0001);
        wr(4'd2, 32'h0002_0000);
        rd("m1_release", 4'd2, 32'h0002_0000);
        wr(4'd2, 32'h0005_0007);
        rd("m1_relock", 4'd2, 32'h0005_0007);

        // out-of-range index 5
        rd("oor_rd", 4'd10, 32'h0);
        wr(4'd10, 32'h0005_0001);
        rd("oor_m1", 4'd2, 32'h0005_0007);
        rd("oor_st", 4'd11, 32'h0);
        rd("oor_m0", 4'd0, 32'h0);

        // read-during-write on mutex 3 returns the old word
        address = 4'd6; data_from_cpu = 32'h0006_0001;
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        chk("rdw_old", data_to_cpu, 32'h0);
        rd("rdw_new", 4'd6, 32'h0006_0001);

        // release interrupt on mutex 0
        wr(4'd1, 32'h4);
        wr(4'd0, 32'h0003_0001);
        wr(4'd0, 32'h0003_0000);
        chk("irq_early", {31'd0, irq}, 32'h0);
        rd("st0_pend", 4'd1, IRQ_BUILD ? 32'hC : 32'h0);
        chk("irq_set", {31'd0, irq}, {31'd0, IRQ_BUILD});
        wr(4'd1, 32'h8);
        rd("st0_ack", 4'd1, 32'h0);
        chk("irq_clr", {31'd0, irq}, 32'h0);

        // lease expiry on mutex 2
        wr(4'd4, 32'h0001_0001);
        idle(9);
        rd("to_last", 4'd4, 32'h0001_0001);
        rd("to_freed", 4'd4, 32'h0);
        rd("to_st", 4'd5, IRQ_BUILD ? 32'hB : 32'h3);
        wr(4'd5, 32'hA);
        rd("to_st_clr", 4'd5, 32'h1);

        // owner rewrite on the expiry cycle refreshes the lease
        wr(4'd4, 32'h0001_0001);
        idle(9);
        wr(4'd4, 32'h0001_0002);
        rd("rw_held", 4'd4, 32'h0001_0002);
        rd("rw_st", 4'd5, 32'h1);
        idle(7);
        rd("rw_last", 4'd4, 32'h0001_0002);
        rd("rw_freed", 4'd4, 32'h0);
        wr(4'd5, 32'hA);

        // failed write on the expiry cycle does not block the timeout
        wr(4'd4, 32'h0001_0001);
        idle(9);
        wr(4'd4, 32'h0004_0009);
        rd("fw_freed", 4'd4, 32'h0);
        rd("fw_st", 4'd5, IRQ_BUILD ? 32'hB : 32'h3);
        chk("irq_quiet", {31'd0, irq}, 32'h0);

        // reset in the middle of operation
        wr(4'd6, 32'h0006_0005);
        rd("pre_rst", 4'd6, 32'h0006_0005);
        reset = 1'b1;
        #1;
        chk("mid_rst_rdata", data_to_cpu, 32'h0);
        chk("mid_rst_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rd("post_rst_m3", 4'd6, 32'h0);
        rd("post_rst_st3", 4'd7, 32'h1);
        rd("post_rst_st0", 4'd1, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
